cpu_access_sequencer: RTL and testbench
=======================================

Name: cpu_access_sequencer

Overview:
- CPU-side initiator for the cache's CPU port: drives MemReadCpu/MemWriteCpu/Address/DataIn and obeys Stall/DataOut.
- Buffers load/store commands from a host or testbench in a command FIFO and issues them one at a time.
- Holds each request stable while the cache stalls and returns read data through a response FIFO.
- Used as the traffic engine for the cache subsystem and later as the CPU stub in integration.

Parameters:
- CMD_DEPTH, 8, command FIFO entries; power of 2, at least 2.
- RSP_DEPTH, 8, response FIFO entries; power of 2, at least 2.
- TIMEOUT, 64, consecutive stall cycles before watchdog error (WATCHDOG_EN only).

Ports:
- CLK in 1: single clock, rising edge.
- RST in 1: synchronous, active-high reset.
- cmd_valid in 1: host command valid.
- cmd_ready out 1: command FIFO not full.
- cmd_write in 1: 1 = store, 0 = load.
- cmd_addr in 10: word address.
- cmd_wdata in 32: store data.
- rsp_valid out 1: response FIFO not empty.
- rsp_ready in 1: host pops a response.
- rsp_addr out 10: address of the load at the FIFO head.
- rsp_rdata out 32: load data at the FIFO head.
- MemReadCpu out 1: load request to cache.
- MemWriteCpu out 1: store request to cache.
- Address out 10: request address.
- DataIn out 32: store data to cache.
- Stall in 1: cache busy; hold the request.
- DataOut in 32: cache load data.
- busy out 1: request outstanding or command FIFO non-empty.
- stall_cycles out 16: saturating count of cycles with a request asserted and Stall=1.
- xfer_count out 16: wrapping count of completed transfers.
- wdog_err out 1: sticky watchdog error; tied 0 when WATCHDOG_EN is undefined.

Behaviour:
- Reset: all outputs are 0 except cmd_ready=1. Both FIFOs are flushed, the FSM goes to IDLE and all counters clear. RST mid-transfer drops the request at the same edge; the cache sees MemReadCpu/MemWriteCpu=0 the next cycle.
- Command FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (count < CMD_DEPTH) from registered count, with no pass-through.
  - A push when full is ignored.
  - Push and pop in the same cycle are both legal.
- FSM states: IDLE and REQ.
- IDLE → REQ at an edge where the cmd FIFO is non-empty and the head is eligible.
  - Eligible means a store, or a load with rsp count < RSP_DEPTH. The rsp count used is the value before any same-cycle pop.
  - On this transition, latch the head into the request registers and pop it.
  - Outputs assert the cycle after that edge. Minimum latency from cmd push edge to request visible is 2 cycles.
- In REQ, exactly one of MemReadCpu/MemWriteCpu is 1. Address and DataIn stay constant (DataIn=0 for loads).
- Completion: at an edge where the request is asserted and Stall=0.
  - Load: push {Address, DataOut} sampled at that edge into the rsp FIFO.
  - Increment xfer_count.
  - If the next cmd head is eligible, latch and pop it and stay in REQ (back-to-back, no bubble). Otherwise go to IDLE and deassert the request.
- Stall=1 in REQ: hold all request outputs and increment stall_cycles (saturates at 0xFFFF).
- A request is never withdrawn except by RST.
- Response FIFO:
  - Pop when rsp_valid && rsp_ready.
  - Push and pop in the same cycle are legal.
  - Overflow cannot occur because slots are reserved at load issue.
- busy = (state==REQ) || cmd FIFO non-empty.

Optional Feature:
- Macro: CPU_SEQ_WATCHDOG_EN.
- Defined:
  - A 16-bit counter counts consecutive Stall=1 cycles in REQ and clears on completion or IDLE.
  - When it reaches TIMEOUT, wdog_err sets and stays set until RST.
  - The request keeps being held.
- Undefined: no counter; wdog_err is constant 0.

Test Plan:
1. Reset: assert RST 2 cycles with cmd_valid=1 → all outputs 0, cmd_ready=1; no command accepted during reset.
2. Store then load, stall model holds Stall=0. Push store 0x05A/0xDEADBEEF, then load 0x05A.
   - MemWriteCpu pulses 1 cycle with Address=0x05A, DataIn=0xDEADBEEF.
   - Then MemReadCpu for 1 cycle; rsp = {0x05A, DataOut}; xfer_count=2.
3. Load miss, Stall=1 for 5 cycles after the request appears → MemReadCpu and Address held 6 cycles, exactly one rsp push, stall_cycles=5.
4. rsp_ready=0, push 9 loads with RSP_DEPTH=8 → exactly 8 loads issue and the 9th waits in IDLE. Pop one rsp → the 9th issues the next cycle.
5. Three stores pushed back-to-back, Stall=0 → requests on 3 consecutive cycles with no bubble; xfer_count=3, busy drops after the third.
6. Stall stuck at 1, TIMEOUT=64 → with CPU_SEQ_WATCHDOG_EN, wdog_err=1 after 64 stall cycles and the request is still held. Then RST mid-stall → request deasserted the next cycle and wdog_err=0.

Source files
------------

// File: rtl/cpu_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_access_sequencer: queued load/store initiator for the cache CPU port.   |
// | Optional watchdog: CPU_SEQ_WATCHDOG_EN.  Revision 1.0                       |
// +----------------------------------------------------------------------------+
module cpu_access_sequencer #(
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [9:0]  rsp_addr,
  output logic [31:0] rsp_rdata,
  output logic        MemReadCpu,
  output logic        MemWriteCpu,
  output logic [9:0]  Address,
  output logic [31:0] DataIn,
  input  logic        Stall,
  input  logic [31:0] DataOut,
  output logic        busy,
  output logic [15:0] stall_cycles,
  output logic [15:0] xfer_count,
  output logic        wdog_err
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [CAW:0]   c_CMD_FULL  = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW+1:0] c_RSP_LIMIT = (RAW+2)'(RSP_DEPTH);

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("cpu_access_sequencer: illegal parameter value");
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;
  state_t state_q, state_d;

  logic            cmd_wr_mem   [CMD_DEPTH];
  logic [9:0]      cmd_addr_mem [CMD_DEPTH];
  logic [31:0]     cmd_data_mem [CMD_DEPTH];
  logic [CAW-1:0]  cmd_wp_q, cmd_rp_q;
  logic [CAW:0]    cmd_cnt_q;

  logic [9:0]      rsp_addr_mem [RSP_DEPTH];
  logic [31:0]     rsp_data_mem [RSP_DEPTH];
  logic [RAW-1:0]  rsp_wp_q, rsp_rp_q;
  logic [RAW:0]    rsp_cnt_q;

  logic            rd_q, wr_q;
  logic [9:0]      addr_q;
  logic [31:0]     wdata_q;
  logic [15:0]     stall_q, xfer_q;

  logic            w_cmd_push, w_issue, w_done, w_rsp_push, w_rsp_pop, w_head_elig;
  logic [RAW+1:0]  w_rsp_resv;

  assign cmd_ready  = (cmd_cnt_q < c_CMD_FULL);
  assign w_cmd_push = cmd_valid && cmd_ready;
  assign rsp_valid  = (rsp_cnt_q != '0);
  assign w_rsp_pop  = rsp_valid && rsp_ready;
  assign w_rsp_push = w_done && rd_q;

  // A load in flight already owns a response slot, so count it as occupied.
  assign w_rsp_resv  = {1'b0, rsp_cnt_q} + {{(RAW+1){1'b0}}, rd_q};
  assign w_head_elig = (cmd_cnt_q != '0) &&
                       (cmd_wr_mem[cmd_rp_q] || (w_rsp_resv < c_RSP_LIMIT));

  always_comb begin
    state_d = state_q;
    w_issue = 1'b0;
    w_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_head_elig) begin
          state_d = S_REQ;
          w_issue = 1'b1;
        end
      end
      S_REQ: begin
        if (!Stall) begin
          w_done = 1'b1;
          if (w_head_elig) w_issue = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_cmd_push) begin
      cmd_wr_mem[cmd_wp_q]   <= cmd_write;
      cmd_addr_mem[cmd_wp_q] <= cmd_addr;
      cmd_data_mem[cmd_wp_q] <= cmd_wdata;
    end
    if (w_rsp_push) begin
      rsp_addr_mem[rsp_wp_q] <= addr_q;
      rsp_data_mem[rsp_wp_q] <= DataOut;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
      rsp_wp_q  <= '0;
      rsp_rp_q  <= '0;
      rsp_cnt_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      stall_q   <= '0;
      xfer_q    <= '0;
    end else begin
      state_q <= state_d;
      if (w_cmd_push) cmd_wp_q <= cmd_wp_q + CAW'(1);
      if (w_issue)    cmd_rp_q <= cmd_rp_q + CAW'(1);
      if (w_cmd_push && !w_issue)      cmd_cnt_q <= cmd_cnt_q + (CAW+1)'(1);
      else if (!w_cmd_push && w_issue) cmd_cnt_q <= cmd_cnt_q - (CAW+1)'(1);

      if (w_rsp_push) rsp_wp_q <= rsp_wp_q + RAW'(1);
      if (w_rsp_pop)  rsp_rp_q <= rsp_rp_q + RAW'(1);
      if (w_rsp_push && !w_rsp_pop)      rsp_cnt_q <= rsp_cnt_q + (RAW+1)'(1);
      else if (!w_rsp_push && w_rsp_pop) rsp_cnt_q <= rsp_cnt_q - (RAW+1)'(1);

      if (w_issue) begin
        rd_q    <= !cmd_wr_mem[cmd_rp_q];
        wr_q    <= cmd_wr_mem[cmd_rp_q];
        addr_q  <= cmd_addr_mem[cmd_rp_q];
        wdata_q <= cmd_wr_mem[cmd_rp_q] ? cmd_data_mem[cmd_rp_q] : 32'd0;
      end else if (w_done) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end

      if (state_q == S_REQ && Stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (w_done) xfer_q <= xfer_q + 16'd1;
    end
  end

`ifdef CPU_SEQ_WATCHDOG_EN
  localparam logic [15:0] c_WD_LIMIT = 16'(TIMEOUT);
  logic [15:0] wd_cnt_q;
  logic        wdog_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
      wdog_q   <= 1'b0;
    end else if (state_q == S_REQ && Stall) begin
      if (wd_cnt_q != 16'hFFFF) wd_cnt_q <= wd_cnt_q + 16'd1;
      if (wd_cnt_q + 16'd1 >= c_WD_LIMIT) wdog_q <= 1'b1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign MemReadCpu   = rd_q;
  assign MemWriteCpu  = wr_q;
  assign Address      = addr_q;
  assign DataIn       = wdata_q;
  assign busy         = (state_q == S_REQ) || (cmd_cnt_q != '0);
  assign stall_cycles = stall_q;
  assign xfer_count   = xfer_q;
  // Head storage is not reset; gate it so reset shows zeros on the response port.
  assign rsp_addr     = rsp_valid ? rsp_addr_mem[rsp_rp_q] : 10'd0;
  assign rsp_rdata    = rsp_valid ? rsp_data_mem[rsp_rp_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_access_sequencer: directed scenarios plus randomized traffic against |
// | a queue-based transaction model.  Revision 1.0                              |
// +----------------------------------------------------------------------------+
module tb_cpu_access_sequencer;

  localparam int CMD_DEPTH = 8;
  localparam int RSP_DEPTH = 8;
  localparam int TIMEOUT   = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, Stall = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, DataOut = '0;
  logic        cmd_ready, rsp_valid, MemReadCpu, MemWriteCpu, busy, wdog_err;
  logic [9:0]  rsp_addr, Address;
  logic [31:0] rsp_rdata, DataIn;
  logic [15:0] stall_cycles, xfer_count;

  int vectors = 0;
  int miscompares = 0;
  bit sb_en = 1'b0;

  cpu_access_sequencer #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .MemReadCpu(MemReadCpu), .MemWriteCpu(MemWriteCpu), .Address(Address), .DataIn(DataIn),
    .Stall(Stall), .DataOut(DataOut), .busy(busy),
    .stall_cycles(stall_cycles), .xfer_count(xfer_count), .wdog_err(wdog_err)
  );

  always #5 CLK = ~CLK;

  // Transaction-level reference: commands accepted in order, issued in order,
  // loads return {addr,data} in order; counters are plain integers.
  typedef struct packed {logic wr; logic [9:0] addr; logic [31:0] data;} cmd_t;
  cmd_t        cmdq[$];
  logic [41:0] rspq[$];
  cmd_t        c;
  int          m_xfer, m_stall, m_wd;
  bit          m_err, p_req, p_done, p_stalled, p_rd, req, done, exp_v;
  logic [9:0]  p_addr;
  logic [31:0] p_data, exp_di;

  always @(negedge CLK) begin
    #2;
    if (!sb_en || RST) begin
      cmdq.delete(); rspq.delete();
      m_xfer = 0; m_stall = 0; m_wd = 0; m_err = 0;
      p_req = 0; p_done = 0; p_stalled = 0;
    end else begin
      req = MemReadCpu || MemWriteCpu;
      vectors++;
      if (MemReadCpu && MemWriteCpu) begin
        miscompares++; $display("FAIL sb_onehot: rd=%b wr=%b, need at most one", MemReadCpu, MemWriteCpu);
      end
      if (p_stalled) begin
        vectors++;
        if (!req || MemReadCpu !== p_rd || Address !== p_addr || DataIn !== p_data) begin
          miscompares++;
          $display("FAIL sb_hold: got rd=%b wr=%b a=%h d=%h, need rd=%b a=%h d=%h held", MemReadCpu, MemWriteCpu, Address, DataIn, p_rd, p_addr, p_data);
        end
      end
      if (req && (!p_req || p_done)) begin
        vectors++;
        if (cmdq.size() == 0) begin
          miscompares++; $display("FAIL sb_issue: request a=%h with no queued command", Address);
        end else begin
          c = cmdq.pop_front();
          exp_di = c.wr ? c.data : 32'd0;
          if (MemWriteCpu !== c.wr || Address !== c.addr || DataIn !== exp_di) begin
            miscompares++;
            $display("FAIL sb_issue: got wr=%b a=%h d=%h, need wr=%b a=%h d=%h", MemWriteCpu, Address, DataIn, c.wr, c.addr, exp_di);
          end
          if (!c.wr) begin
            vectors++;
            if (rspq.size() >= RSP_DEPTH) begin
              miscompares++; $display("FAIL sb_rsp_slot: load issued with %0d responses held, need < %0d", rspq.size(), RSP_DEPTH);
            end
          end
        end
      end
      exp_v = (rspq.size() != 0);
      vectors++;
      if (rsp_valid !== exp_v) begin
        miscompares++; $display("FAIL sb_rsp_valid: got %b need %b", rsp_valid, exp_v);
      end else if (exp_v && {rsp_addr, rsp_rdata} !== rspq[0]) begin
        miscompares++; $display("FAIL sb_rsp_data: got %h/%h need %h/%h", rsp_addr, rsp_rdata, rspq[0][41:32], rspq[0][31:0]);
      end
      vectors++;
      if (cmd_ready !== (cmdq.size() < CMD_DEPTH)) begin
        miscompares++; $display("FAIL sb_cmd_ready: got %b with %0d queued", cmd_ready, cmdq.size());
      end
      vectors++;
      if (busy !== (req || cmdq.size() != 0)) begin
        miscompares++; $display("FAIL sb_busy: got %b, req=%b queued=%0d", busy, req, cmdq.size());
      end
      vectors++;
      if (xfer_count !== 16'(m_xfer) || stall_cycles !== 16'(m_stall)) begin
        miscompares++; $display("FAIL sb_counters: got xfer=%0d stall=%0d need xfer=%0d stall=%0d", xfer_count, stall_cycles, 16'(m_xfer), m_stall);
      end
      vectors++;
      if (wdog_err !== m_err) begin
        miscompares++; $display("FAIL sb_wdog: got %b need %b", wdog_err, m_err);
      end
      done = req && !Stall;
      if (done) m_xfer++;
      if (exp_v && rsp_ready) void'(rspq.pop_front());
      if (done && MemReadCpu) rspq.push_back({Address, DataOut});
      if (req && Stall) begin
        if (m_stall < 65535) m_stall++;
        m_wd++;
`ifdef CPU_SEQ_WATCHDOG_EN
        if (m_wd >= TIMEOUT) m_err = 1'b1;
`endif
      end else begin
        m_wd = 0;
      end
      if (cmd_valid && cmdq.size() < CMD_DEPTH) cmdq.push_back({cmd_write, cmd_addr, cmd_wdata});
      p_req = req; p_done = done; p_stalled = req && Stall;
      p_rd = MemReadCpu; p_addr = Address; p_data = DataIn;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; cmd_valid = 1'b0; Stall = 1'b0; rsp_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h155; cmd_wdata = $urandom;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0; cmd_valid = 1'b0;
    #1;
    vectors++;
    if ({MemReadCpu, MemWriteCpu, Address, DataIn} !== 44'd0) begin
      miscompares++; $display("FAIL reset_req: got rd=%b wr=%b a=%h d=%h need all 0", MemReadCpu, MemWriteCpu, Address, DataIn);
    end
    vectors++;
    if ({rsp_valid, rsp_addr, rsp_rdata} !== 43'd0) begin
      miscompares++; $display("FAIL reset_rsp: got v=%b a=%h d=%h need 0", rsp_valid, rsp_addr, rsp_rdata);
    end
    vectors++;
    if ({busy, stall_cycles, xfer_count, wdog_err} !== 34'd0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_status: got busy=%b stall=%0d xfer=%0d wd=%b rdy=%b need 0/0/0/0/1", busy, stall_cycles, xfer_count, wdog_err, cmd_ready);
    end
    @(negedge CLK); #1;
    vectors++;
    if (busy !== 1'b0 || MemWriteCpu !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_accept: got busy=%b wr=%b need 0/0", busy, MemWriteCpu);
    end
    sb_en = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    @(negedge CLK); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h05A; cmd_wdata = 32'hDEADBEEF;
    @(negedge CLK); cmd_write = 1'b0; cmd_wdata = $urandom;
    @(negedge CLK); cmd_valid = 1'b0; DataOut = d; #1;
    vectors++;
    if (MemWriteCpu !== 1'b1 || MemReadCpu !== 1'b0 || Address !== 10'h05A || DataIn !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL store_issue: got wr=%b rd=%b a=%h d=%h need 1/0/05a/deadbeef", MemWriteCpu, MemReadCpu, Address, DataIn);
    end
    @(negedge CLK); #1;
    vectors++;
    if (MemWriteCpu !== 1'b0 || MemReadCpu !== 1'b1 || Address !== 10'h05A || DataIn !== 32'd0) begin
      miscompares++; $display("FAIL load_issue: got wr=%b rd=%b a=%h d=%h need 0/1/05a/0", MemWriteCpu, MemReadCpu, Address, DataIn);
    end
    @(negedge CLK); #1;
    vectors++;
    if (MemReadCpu !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 10'h05A || rsp_rdata !== d) begin
      miscompares++; $display("FAIL load_rsp: got rd=%b v=%b a=%h d=%h need 0/1/05a/%h", MemReadCpu, rsp_valid, rsp_addr, rsp_rdata, d);
    end
    vectors++;
    if (xfer_count !== 16'd2) begin
      miscompares++; $display("FAIL store_load_xfer: got %0d need 2", xfer_count);
    end
    rsp_ready = 1'b1;
    @(negedge CLK); rsp_ready = 1'b0; #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL store_load_pop: got rsp_valid=%b need 0", rsp_valid);
    end
  endtask

  task automatic test_load_stall();
    logic [9:0]  a;
    logic [31:0] d_done;
    int held, n, k;
    do_reset();
    a = 10'($urandom); d_done = '0;
    @(negedge CLK); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    @(negedge CLK); cmd_valid = 1'b0; #1;
    for (k = 0; k < 10 && !MemReadCpu; k++) begin @(negedge CLK); #1; end
    vectors++;
    if (MemReadCpu !== 1'b1) begin
      miscompares++; $display("FAIL stall_load_appear: got rd=%b need 1 within 10 cycles", MemReadCpu);
    end
    held = 0; n = 0;
    while (MemReadCpu && n < 20) begin
      held++;
      vectors++;
      if (Address !== a) begin
        miscompares++; $display("FAIL stall_addr: got %h need %h", Address, a);
      end
      Stall = (n < 5); DataOut = $urandom;
      if (n == 5) d_done = DataOut;
      n++;
      @(negedge CLK); #1;
    end
    Stall = 1'b0;
    vectors++;
    if (held != 6) begin
      miscompares++; $display("FAIL stall_held: got %0d cycles need 6", held);
    end
    vectors++;
    if (stall_cycles !== 16'd5) begin
      miscompares++; $display("FAIL stall_count: got %0d need 5", stall_cycles);
    end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_addr !== a || rsp_rdata !== d_done) begin
      miscompares++; $display("FAIL stall_rsp: got v=%b a=%h d=%h need 1/%h/%h", rsp_valid, rsp_addr, rsp_rdata, a, d_done);
    end
    rsp_ready = 1'b1;
    @(negedge CLK); rsp_ready = 1'b0; #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_single_rsp: got rsp_valid=%b need 0", rsp_valid);
    end
  endtask

  task automatic test_rsp_backpressure();
    logic [9:0] addrs [9];
    int pushed, issued, k;
    do_reset();
    for (int i = 0; i < 9; i++) addrs[i] = 10'(i * 37 + 3);
    pushed = 0; issued = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLK);
      cmd_valid = (pushed < 9); cmd_write = 1'b0; cmd_addr = addrs[pushed < 9 ? pushed : 8];
      DataOut = $urandom;
      #1;
      if (cmd_valid && cmd_ready) pushed++;
      if (MemReadCpu) issued++;
    end
    cmd_valid = 1'b0;
    vectors++;
    if (pushed != 9 || issued != 8) begin
      miscompares++; $display("FAIL bp_issue_count: got pushed=%0d issued=%0d need 9/8", pushed, issued);
    end
    vectors++;
    if (MemReadCpu !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_wait: got rd=%b busy=%b rspv=%b need 0/1/1", MemReadCpu, busy, rsp_valid);
    end
    @(negedge CLK); rsp_ready = 1'b1;
    @(negedge CLK); rsp_ready = 1'b0; #1;
    for (k = 0; k < 2 && !MemReadCpu; k++) begin @(negedge CLK); #1; end
    vectors++;
    if (MemReadCpu !== 1'b1 || Address !== addrs[8]) begin
      miscompares++; $display("FAIL bp_release: got rd=%b a=%h need 1/%h", MemReadCpu, Address, addrs[8]);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) @(negedge CLK);
    rsp_ready = 1'b0; #1;
    vectors++;
    if (rsp_valid !== 1'b0 || xfer_count !== 16'd9) begin
      miscompares++; $display("FAIL bp_drain: got rspv=%b xfer=%0d need 0/9", rsp_valid, xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ba [3];
    bit         wr_seen [8];
    bit         busy_seen [8];
    logic [9:0] a_seen [8];
    bit         exp_wr;
    do_reset();
    for (int i = 0; i < 3; i++) ba[i] = 10'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i < 3) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ba[i]; cmd_wdata = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      wr_seen[i] = MemWriteCpu; a_seen[i] = Address; busy_seen[i] = busy;
    end
    for (int i = 0; i < 8; i++) begin
      exp_wr = (i >= 2 && i <= 4);
      vectors++;
      if (wr_seen[i] !== exp_wr || (exp_wr && a_seen[i] !== ba[i - 2])) begin
        miscompares++; $display("FAIL b2b_cycle%0d: got wr=%b a=%h need wr=%b a=%h", i, wr_seen[i], a_seen[i], exp_wr, exp_wr ? ba[i > 1 ? i - 2 : 0] : 10'd0);
      end
    end
    vectors++;
    if (busy_seen[4] !== 1'b1 || busy_seen[5] !== 1'b0 || xfer_count !== 16'd3) begin
      miscompares++; $display("FAIL b2b_busy: got busy %b->%b xfer=%0d need 1->0 xfer=3", busy_seen[4], busy_seen[5], xfer_count);
    end
  endtask

  task automatic test_watchdog();
    logic [9:0] a;
    bit         exp_err;
    int         k;
`ifdef CPU_SEQ_WATCHDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    a = 10'($urandom);
    @(negedge CLK); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    @(negedge CLK); cmd_valid = 1'b0; #1;
    for (k = 0; k < 10 && !MemReadCpu; k++) begin @(negedge CLK); #1; end
    Stall = 1'b1;
    for (int s = 1; s <= TIMEOUT; s++) begin
      @(negedge CLK); #1;
      if (s == TIMEOUT - 1) begin
        vectors++;
        if (wdog_err !== 1'b0) begin
          miscompares++; $display("FAIL wdog_early: got %b after %0d stalls need 0", wdog_err, s);
        end
      end
    end
    vectors++;
    if (wdog_err !== exp_err) begin
      miscompares++; $display("FAIL wdog_set: got %b need %b", wdog_err, exp_err);
    end
    vectors++;
    if (MemReadCpu !== 1'b1 || Address !== a || stall_cycles !== 16'(TIMEOUT)) begin
      miscompares++; $display("FAIL wdog_hold: got rd=%b a=%h stall=%0d need 1/%h/%0d", MemReadCpu, Address, stall_cycles, a, TIMEOUT);
    end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; #1;
    vectors++;
    if (MemReadCpu !== 1'b0 || wdog_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL wdog_reset: got rd=%b wd=%b busy=%b need 0/0/0", MemReadCpu, wdog_err, busy);
    end
    Stall = 1'b0;
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      cmd_valid = $urandom_range(0, 1); cmd_write = $urandom_range(0, 1);
      cmd_addr  = 10'($urandom); cmd_wdata = $urandom;
      Stall     = ($urandom_range(0, 3) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      DataOut   = $urandom;
    end
    @(negedge CLK); cmd_valid = 1'b0; Stall = 1'b0; rsp_ready = 1'b1; #1;
    for (k = 0; k < 60 && (busy || rsp_valid); k++) begin @(negedge CLK); #1; end
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL random_drain: got busy=%b rspv=%b need 0/0", busy, rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_stall();
    test_rsp_backpressure();
    test_back_to_back();
    test_watchdog();
    test_random();
    @(negedge CLK);
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
